mem_initiator: RTL and testbench

Initiator-side controller for the DLX test-bench memory protocol: accepts single load/store requests from the datapath, drives ADDRESS/ENABLE/READNOTWRITE on the memory side, drives or releases the shared INOUT_DATA bus, and waits for DATA_READY. It returns read data or a write acknowledge, or flags an error after a bounded wait. It sits between the DLX core's memory stage and a read/write memory model.

---
 rtl/mem_initiator.sv | 117 +++++++++++
 tb/tb_mem_initiator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_initiator.sv
// mem_initiator: initiator-side controller for the DLX test-bench memory
// protocol. Issues one load/store at a time on ADDRESS/ENABLE/READNOTWRITE,
// drives INOUT_DATA for writes, waits (bounded) for DATA_READY and reports
// completion or timeout with a one-cycle rsp_valid pulse.
module mem_initiator #(
  parameter int ADDRESS_SIZE   = 16,
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  input  logic                    req_rnw,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic [0:WORD_SIZE-1]    req_wdata,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [0:WORD_SIZE-1]    rsp_rdata,
  output logic                    stall,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic                    ENABLE,
  output logic                    READNOTWRITE,
  inout  wire logic [0:WORD_SIZE-1] INOUT_DATA,
  input  logic                    DATA_READY
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [0:WORD_SIZE-1] wdata_q;
  logic [0:WORD_SIZE-1] rdata_d;
  logic                 rsp_valid_d, rsp_err_d;
  logic                 accept;
  logic                 drive_en;

  // Bus is driven only while a write is in ACCESS; decoded from registered
  // state so an asynchronous reset releases it immediately.
  assign drive_en   = (state_q == ACCESS) && !READNOTWRITE;
  assign INOUT_DATA = drive_en ? wdata_q : 'z;

  // Next-state, wait counter and next response values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rdata_d     = rsp_rdata;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // DATA_READY is tested first so success wins over a same-edge timeout.
        if (DATA_READY) begin
          rsp_valid_d = 1'b1;
          if (READNOTWRITE) rdata_d = INOUT_DATA;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          cnt_d       = '0;
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!DATA_READY || cnt_q == CNT_LAST) state_d = IDLE;
        else cnt_d = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wdata_q      <= '0;
      ADDRESS      <= '0;
      READNOTWRITE <= 1'b1;
      ENABLE       <= 1'b0;
      req_ready    <= 1'b1;
      stall        <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ENABLE    <= (state_d == ACCESS);
      req_ready <= (state_d == IDLE);
      stall     <= (state_d != IDLE);
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rdata_d;
      if (accept) begin
        ADDRESS      <= req_addr;
        READNOTWRITE <= req_rnw;
        wdata_q      <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: directed vector table, an
// asynchronous reset during a write, then randomized transactions against a
// transaction-level model of timing and read-data behaviour.
module tb_mem_initiator;
  localparam int AW = 16;
  localparam int WW = 32;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_rnw;
  logic [AW-1:0] req_addr;
  logic [0:WW-1] req_wdata;
  logic          req_ready, rsp_valid, rsp_err, stall;
  logic [0:WW-1] rsp_rdata;
  logic [AW-1:0] ADDRESS;
  logic          ENABLE, READNOTWRITE, DATA_READY;
  wire  [0:WW-1] bus;

  // Memory side: drives the bus whenever the controller is not in a write
  // access (read data during reads, a probe pattern otherwise).
  logic [0:WW-1] mem_val;
  logic          mem_oe;
  assign mem_oe = !(ENABLE && !READNOTWRITE);
  assign bus    = mem_oe ? mem_val : 'z;

  mem_initiator #(.ADDRESS_SIZE(AW), .WORD_SIZE(WW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .stall(stall), .ADDRESS(ADDRESS), .ENABLE(ENABLE),
    .READNOTWRITE(READNOTWRITE), .INOUT_DATA(bus), .DATA_READY(DATA_READY)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [0:WW-1] mdl_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [0:WW-1] wdata;
    int            k;       // edge after acceptance where DATA_READY first rises, 0 = never
    logic [0:WW-1] rdata;   // word the memory returns on a read
    int            hold;    // extra edges DATA_READY stays high after the ack
    bit            keep;    // datapath keeps its request asserted while stalled
    logic          exp_err;
    logic [0:WW-1] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic rnw, input logic [AW-1:0] addr,
                              input logic [0:WW-1] wdata, input int k,
                              input logic [0:WW-1] rdata, input int hold,
                              input bit keep, input logic exp_err,
                              input logic [0:WW-1] exp_rdata);
    vec_t v;
    v.rnw = rnw; v.addr = addr; v.wdata = wdata; v.k = k; v.rdata = rdata;
    v.hold = hold; v.keep = keep; v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // Runs one transaction from a negedge with the controller idle, checking
  // every cycle, and returns at the negedge after it is idle again.
  task automatic run_txn(input vec_t v);
    int  e, r, last;
    bit  ok;
    ok   = (v.k >= 1 && v.k <= T);
    e    = ok ? v.k : T;
    r    = ok ? ((v.hold + 1 < T) ? v.hold + 1 : T) : 1;
    last = e + r;
    mem_val    = v.rnw ? v.rdata : $urandom();
    req_valid  = 1'b1;
    req_rnw    = v.rnw;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    DATA_READY = 1'b0;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      if (i < e) begin
        chk("enable_access", ENABLE, 1);
        chk("address", ADDRESS, v.addr);
        chk("rnw", READNOTWRITE, v.rnw);
        chk("bus_access", bus, v.rnw ? mem_val : v.wdata);
        chk("rsp_valid_wait", rsp_valid, 0);
        chk("stall_access", stall, 1);
        chk("ready_access", req_ready, 0);
        chk("rdata_hold", rsp_rdata, mdl_rdata);
      end else if (i == e) begin
        if (!v.exp_err && v.rnw) mdl_rdata = v.rdata;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, v.exp_err);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rdata_model", rsp_rdata, mdl_rdata);
        chk("enable_resp", ENABLE, 0);
        chk("stall_resp", stall, 1);
        chk("bus_resp", bus, mem_val);
      end else begin
        chk("rsp_valid_single", rsp_valid, 0);
        chk("enable_off", ENABLE, 0);
        chk("bus_off", bus, mem_val);
        chk("stall_rel", stall, (i < last) ? 1 : 0);
        chk("ready_rel", req_ready, (i < last) ? 0 : 1);
        chk("rdata_after", rsp_rdata, mdl_rdata);
      end
      if (i == last) begin
        req_valid  = 1'b0;
        DATA_READY = 1'b0;
      end else begin
        DATA_READY = ok && (i + 1 >= v.k) && (i + 1 <= v.k + v.hold);
        if (!v.keep) begin
          req_valid = 1'($urandom_range(0, 1));
          req_rnw   = 1'($urandom_range(0, 1));
          req_addr  = AW'($urandom());
          req_wdata = $urandom();
        end
      end
    end
  endtask

  vec_t tbl[8];

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_wdata = '0;
    DATA_READY = 1'b0; mem_val = 32'hA5A5A5A5; mdl_rdata = '0;

    tbl[0] = mk(1, 16'h0010, 32'h0BADF00D, 1,  32'hDEADBEEF, 0,     0, 0, 32'hDEADBEEF);
    tbl[1] = mk(0, 16'h0020, 32'h12345678, 3,  32'h0,        0,     0, 0, 32'hDEADBEEF);
    tbl[2] = mk(1, 16'h0030, 32'h0,        0,  32'h11111111, 0,     0, 1, 32'hDEADBEEF);
    tbl[3] = mk(1, 16'h0040, 32'h0,        16, 32'hCAFEF00D, 0,     0, 0, 32'hCAFEF00D);
    tbl[4] = mk(1, 16'h0050, 32'h0,        1,  32'h01234567, 3,     1, 0, 32'h01234567);
    tbl[5] = mk(1, 16'h0054, 32'h0,        2,  32'h89ABCDEF, 3,     1, 0, 32'h89ABCDEF);
    tbl[6] = mk(0, 16'h0060, 32'h55AA33CC, 16, 32'h0,        T + 2, 0, 0, 32'h89ABCDEF);
    tbl[7] = mk(0, 16'hFFFF, 32'hFFFFFFFF, 0,  32'h0,        0,     0, 1, 32'h89ABCDEF);

    #1 rst = 1'b0;
    #2;
    chk("rst_ready", req_ready, 1);
    chk("rst_stall", stall, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_address", ADDRESS, 0);
    chk("rst_enable", ENABLE, 0);
    chk("rst_rnw", READNOTWRITE, 1);
    chk("rst_bus", bus, mem_val);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    chk("idle_enable", ENABLE, 0);

    for (int n = 0; n < 8; n++) run_txn(tbl[n]);

    // Asynchronous reset in the middle of a write access.
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 16'h0ABC; req_wdata = 32'h5A5A0F0F;
    DATA_READY = 1'b0; mem_val = 32'hC3C3C3C3;
    @(negedge clk);
    chk("mw_enable", ENABLE, 1);
    chk("mw_rnw", READNOTWRITE, 0);
    chk("mw_bus", bus, 32'h5A5A0F0F);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mw_rst_enable", ENABLE, 0);
    chk("mw_rst_bus", bus, 32'hC3C3C3C3);
    chk("mw_rst_ready", req_ready, 1);
    chk("mw_rst_stall", stall, 0);
    chk("mw_rst_rdata", rsp_rdata, 0);
    chk("mw_rst_rnw", READNOTWRITE, 1);
    mdl_rdata = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mw_no_rsp", rsp_valid, 0);
      chk("mw_idle_enable", ENABLE, 0);
      chk("mw_idle_ready", req_ready, 1);
    end

    // Randomized transactions; expectations from the transaction model.
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int   sel;
      v.rnw   = 1'($urandom_range(0, 1));
      v.addr  = AW'($urandom());
      v.wdata = $urandom();
      v.rdata = $urandom();
      sel     = int'($urandom_range(0, 3));
      v.k     = (sel == 0) ? 0 : int'($urandom_range(1, T));
      sel     = int'($urandom_range(0, 7));
      v.hold  = (sel == 0) ? T + 1 : int'($urandom_range(0, 4));
      v.keep  = 1'($urandom_range(0, 1));
      v.exp_err   = (v.k == 0);
      v.exp_rdata = (v.rnw && v.k != 0) ? v.rdata : mdl_rdata;
      run_txn(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
